// File: rtl/tns_pkg.sv
// TNS decoder shared constants.
// Codeword weights, illegal pattern, radix and output width helper.
package tns_pkg;

    localparam logic [2:0] TNS_W2 = 3'd4;
    localparam logic [2:0] TNS_W1 = 3'd2;
    localparam logic [2:0] TNS_W0 = 3'd1;

    localparam logic [2:0] TNS_ILLEGAL = 3'b111;

    localparam int TNS_RADIX = 7;

    // Bits needed to hold any value below TNS_RADIX**n_grp.
    function automatic int tns_data_w(input int n_grp);
        longint unsigned span;
        span = 1;
        for (int i = 0; i < n_grp; i++) begin
            span = span * 64'(TNS_RADIX);
        end
        return $clog2(span);
    endfunction

endpackage

// File: rtl/tns_digit_dec.sv
// Single TNS codeword decoder.
// Maps a 3-bit codeword to its digit and flags the forbidden pattern.
module tns_digit_dec
    import tns_pkg::*;
(
    input  logic [2:0] code,
    output logic [2:0] digit,
    output logic       illegal
);

    // Weighted sum of codeword bits plus illegal-pattern detect.
    always_comb begin
        digit = '0;
        if (code[2]) digit = digit + TNS_W2;
        if (code[1]) digit = digit + TNS_W1;
        if (code[0]) digit = digit + TNS_W0;
        illegal = (code == TNS_ILLEGAL);
    end

endmodule

// File: rtl/tns_dec_stream.sv
// Streaming multi-group TNS decoder.
// Two-stage valid/ready pipeline: digit decode, then radix-7 combine.
module tns_dec_stream
    import tns_pkg::*;
#(
    parameter  int N_GRP  = 4,
    parameter  int CNT_W  = 16,
    localparam int DATA_W = tns_data_w(N_GRP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*N_GRP-1:0] codein,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  dataout,
    output logic               err,
    output logic [N_GRP-1:0]   err_grp,
    output logic [CNT_W-1:0]   err_cnt,
    input  logic               err_clr
);

    localparam int AW = DATA_W + 3;

    logic [N_GRP-1:0][2:0] dig;
    logic [N_GRP-1:0]      ill;

    logic                  s1_valid;
    logic [N_GRP-1:0][2:0] s1_dig;
    logic [N_GRP-1:0]      s1_ill;

    logic                  s2_adv;
    logic                  s1_load;
    logic [AW-1:0]         acc;

    for (genvar g = 0; g < N_GRP; g++) begin : g_dec
        tns_digit_dec u_dec (
            .code    (codein[3*g +: 3]),
            .digit   (dig[g]),
            .illegal (ill[g])
        );
    end

    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;
    assign s1_load  = in_valid & in_ready;

    // Stage 1 occupancy follows the input whenever the slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload only captures accepted beats, so idle X never enters.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_dig <= dig;
            s1_ill <= ill;
        end
    end

    // Horner combine, most significant group first.
    always_comb begin
        acc = '0;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            acc = acc * AW'(TNS_RADIX) + AW'(s1_dig[g]);
        end
    end

    // Output register; holds its payload while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dataout   <= '0;
            err       <= 1'b0;
            err_grp   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                err     <= |s1_ill;
                err_grp <= s1_ill;
                dataout <= (|s1_ill) ? '0 : acc[DATA_W-1:0];
            end
        end
    end

    // Saturating count of delivered error beats; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid & out_ready & err & ~&err_cnt) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tns_dec_stream.sv
// Testbench for tns_dec_stream.
// Vector table, directed corner sequences and a randomized scoreboard.
module tb_tns_dec_stream;

    typedef struct {
        logic [11:0] code;
        logic [11:0] d;
        logic        e;
        logic [3:0]  g;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        logic        e;
        logic [3:0]  g;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] codein;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] dataout;
    logic        err;
    logic [3:0]  err_grp;
    logic [15:0] err_cnt;
    logic        err_clr;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_codein;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [11:0] s_dataout;
    logic        s_err;
    logic [3:0]  s_err_grp;
    logic [1:0]  s_err_cnt;
    logic        s_err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tns_dec_stream #(.N_GRP(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codein    (codein),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .err       (err),
        .err_grp   (err_grp),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    tns_dec_stream #(.N_GRP(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .codein    (s_codein),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .dataout   (s_dataout),
        .err       (s_err),
        .err_grp   (s_err_grp),
        .err_cnt   (s_err_cnt),
        .err_clr   (s_err_clr)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Base-7 encoding of v, group 0 least significant.
    function automatic logic [11:0] enc(input int v);
        logic [11:0] c;
        int r;
        r = v;
        for (int g = 0; g < 4; g++) begin
            c[3*g +: 3] = 3'(r % 7);
            r = r / 7;
        end
        return c;
    endfunction

    // Reference: value = sum digit_g * 7**g, any 3'b111 group poisons it.
    function automatic exp_t model(input logic [11:0] c);
        exp_t r;
        int   v;
        int   p;
        int   dg;
        v = 0;
        p = 1;
        r.g = '0;
        for (int g = 0; g < 4; g++) begin
            dg = int'(c[3*g +: 3]);
            if (dg == 7) r.g[g] = 1'b1;
            v = v + dg * p;
            p = p * 7;
        end
        r.e = |r.g;
        r.d = r.e ? 12'd0 : 12'(v);
        return r;
    endfunction

    function automatic vec_t mk(input logic [11:0] c, input int d,
                                input logic e, input logic [3:0] g);
        vec_t v;
        v.code = c;
        v.d    = 12'(d);
        v.e    = e;
        v.g    = g;
        return v;
    endfunction

    function automatic logic [11:0] rand_code();
        logic [11:0] c;
        for (int g = 0; g < 4; g++) begin
            if ($urandom % 12 == 0) c[3*g +: 3] = 3'b111;
            else c[3*g +: 3] = 3'($urandom % 7);
        end
        return c;
    endfunction

    exp_t        q[$];
    logic        mon_en = 1'b0;
    int          m_cnt;
    logic        m_hold;
    logic [17:0] m_held;

    // Scoreboard: decide the coming edge's handshakes from mid-cycle values.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (mon_en) begin
            chk("rnd_cnt", err_cnt, m_cnt);
            if (m_hold) begin
                chk("rnd_hold", {out_valid, err, err_grp, dataout}, m_held);
            end
            hs = out_valid && out_ready;
            e.e = 1'b0;
            if (hs) begin
                chk("rnd_qnonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_data", dataout, e.d);
                    chk("rnd_err", err, e.e);
                    chk("rnd_grp", err_grp, e.g);
                end
            end
            if (err_clr) m_cnt = 0;
            else if (hs && e.e && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (in_valid && in_ready) q.push_back(model(codein));
            m_hold = out_valid && !out_ready;
            m_held = {out_valid, err, err_grp, dataout};
        end
    end

    initial begin
        vec_t        vt[$];
        int          exp_cnt;
        int          sent;
        int          recv;
        logic        saw_stall;
        logic        held_v;
        logic [17:0] held;

        rst = 1'b1;
        in_valid = 1'b0;
        codein = '0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        s_in_valid = 1'b0;
        s_codein = '0;
        s_out_ready = 1'b1;
        s_err_clr = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_valid", out_valid, 0);
        chk("rst_data", dataout, 0);
        chk("rst_err", err, 0);
        chk("rst_grp", err_grp, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sat_cnt", s_err_cnt, 0);

        vt.push_back(mk(12'b000_000_000_001, 1, 1'b0, 4'b0000));
        vt.push_back(mk(12'b000_000_001_000, 7, 1'b0, 4'b0000));
        vt.push_back(mk(12'b001_000_000_000, 343, 1'b0, 4'b0000));
        vt.push_back(mk(12'b110_110_110_110, 2400, 1'b0, 4'b0000));
        for (int d = 0; d < 7; d++) begin
            vt.push_back(mk(12'(d), d, 1'b0, 4'b0000));
        end
        vt.push_back(mk(12'b001_111_001_001, 0, 1'b1, 4'b0100));

        exp_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            in_valid = 1'b1;
            codein = vt[i].code;
            step();
            in_valid = 1'b0;
            codein = 'x;
            chk("vec_early", out_valid, 0);
            step();
            chk("vec_valid", out_valid, 1);
            chk("vec_data", dataout, vt[i].d);
            chk("vec_err", err, vt[i].e);
            chk("vec_grp", err_grp, vt[i].g);
            step();
            if (vt[i].e) exp_cnt++;
            chk("vec_cnt", err_cnt, exp_cnt);
        end

        in_valid = 1'b1;
        codein = 12'b111_000_000_000;
        step();
        in_valid = 1'b0;
        codein = 'x;
        step();
        chk("clr_err", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);

        sent = 0;
        recv = 0;
        saw_stall = 1'b0;
        held_v = 1'b0;
        held = '0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            in_valid = (sent < 5);
            codein = in_valid ? enc(sent + 1) : 'x;
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (held_v) begin
                chk("bp_hold", {out_valid, err, err_grp, dataout}, held);
            end
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                chk("bp_data", dataout, recv + 1);
                recv++;
            end
            held_v = out_valid && !out_ready;
            held = {out_valid, err, err_grp, dataout};
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall", saw_stall, 1);
        chk("bp_count", recv, 5);

        in_valid = 1'b1;
        codein = 12'b000_000_111_000;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("pre_rst_cnt", err_cnt, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        codein = enc(2);
        step();
        codein = enc(3);
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        codein = enc(5);
        step();
        in_valid = 1'b0;
        chk("post_rst_early", out_valid, 0);
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", dataout, 5);
        step();
        chk("post_rst_empty", out_valid, 0);

        for (int k = 0; k < 5; k++) begin
            s_in_valid = 1'b1;
            s_codein = 12'b111_000_000_000;
            step();
        end
        s_in_valid = 1'b0;
        repeat (3) step();
        chk("sat_cnt", s_err_cnt, 3);
        chk("sat_grp", s_err_grp, 4'b1000);
        repeat (2) step();
        chk("sat_stay", s_err_cnt, 3);

        rst = 1'b1;
        step();
        rst = 1'b0;
        m_cnt = 0;
        m_hold = 1'b0;
        m_held = '0;
        mon_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom % 10) < 7;
            codein = in_valid ? rand_code() : 'x;
            out_ready = ($urandom % 10) < 6;
            err_clr = ($urandom % 32) == 0;
            step();
        end
        in_valid = 1'b0;
        codein = 'x;
        out_ready = 1'b1;
        err_clr = 1'b0;
        repeat (6) step();
        mon_en = 1'b0;
        chk("rnd_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tns_dec_stream.md
Name: tns_dec_stream

Overview:
- Streaming, parametrised successor to the single-codeword TNS decoder.
- Each beat carries N_GRP 3-bit tribonacci (TNS) codewords from the CAC link receiver.
- Each group is decoded to a digit 0..6 and checked for the forbidden pattern 3'b111; the digits are then combined, mixed-radix (radix 7), into one binary word.
- Two-stage pipeline with valid/ready flow control; sits between the link deserialiser and the data sink.

Parameters:
- N_GRP, 4, number of 3-bit codeword groups per beat (1..8).
- CNT_W, 16, width of the saturating illegal-codeword counter.
- DATA_W (localparam), ceil(log2(7**N_GRP)); 12 for the default N_GRP.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- codein  in  3*N_GRP  codewords; group g occupies codein[3g+2:3g]; group N_GRP-1 is the most significant.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- dataout  out  DATA_W  decoded binary value.
- err  out  1  beat contained at least one illegal group.
- err_grp  out  N_GRP  per-group illegal flags.
- err_cnt  out  CNT_W  saturating count of beats with err=1.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset: synchronous, active-high. On the first rising edge with rst=1, all pipeline valids clear and every output register goes to zero: out_valid=0, dataout=0, err=0, err_grp=0, err_cnt=0.
- in_ready is combinational: in_ready = !s1_valid | s2_adv; it is 1 on the cycle after reset.
- Stage 1 loads when in_valid & in_ready. Per group:
  - digit = 4*c[2] + 2*c[1] + c[0], 3 bits wide.
  - illegal = (c == 3'b111).
- Stage 2 (output register):
  - Advances when s2_adv = !out_valid | out_ready.
  - Loads dataout = Horner sum over groups, MSB group first (acc = acc*7 + digit), computed at DATA_W+3 bits and truncated to DATA_W.
  - If any group is illegal: dataout = 0, err = 1, err_grp = the illegal mask.
  - out_valid takes s1_valid when s2_adv.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput: 1 beat/cycle.
- Backpressure:
  - While out_valid & !out_ready, stage 2 holds dataout, err and err_grp stable.
  - Stage 1 holds if it is full; in_ready drops.
  - No beat is dropped or duplicated.
- err_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) with err=1.
  - Saturates at 2**CNT_W-1.
  - err_clr has priority over a same-cycle increment; the result is 0.
- Reset mid-transfer discards in-flight beats. There is no partial output.
- X on codein while in_valid=0 must not propagate into any register.

Decomposition:
- Package tns_pkg holds:
  - TNS_W2=4, TNS_W1=2, TNS_W0=1.
  - TNS_ILLEGAL=3'b111.
  - TNS_RADIX=7.
  - A function returning DATA_W for a given N_GRP.
- One sub-module, tns_digit_dec: 3-bit codeword in, 3-bit digit plus illegal flag out, purely combinational. It is instantiated N_GRP times in stage 1.

Test Plan:
- Codeword mapping: N_GRP=4, codein=12'b000_000_000_001 -> dataout=1 two cycles later. 12'b000_000_001_000 -> 7. 12'b001_000_000_000 -> 343.
- Maximum value: all groups 3'b110 -> dataout=2400, err=0. Sweep all 7 legal digits in group 0 -> dataout 0..6.
- Illegal group: group 2 = 3'b111, others 3'b001 -> err=1, err_grp=4'b0100, dataout=0, err_cnt 0->1. Then err_clr and a simultaneous err beat -> err_cnt=0.
- Backpressure: 5 back-to-back beats with values 1..5, out_ready low for cycles 3-5 -> in_ready drops. All 5 are delivered in order, with the held outputs stable during the stall.
- Reset mid-stream: rst asserted with both stages full -> next cycle out_valid=0, err_cnt=0, in_ready=1. The next beat emerges after 2 cycles.
- Saturation: CNT_W=2, 5 illegal beats -> err_cnt reaches 3 and stays at 3.
